seq_hex_fmt: RTL and testbench



---
 rtl/seq_hex_fmt_pkg.sv | 26 ++
 rtl/seq_hex_fmt_if.sv | 22 ++
 rtl/seq_hex_ascii.sv | 17 +
 rtl/seq_hex_fmt.sv | 150 +++++++++++++++
 tb/tb_seq_hex_fmt.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_hex_fmt_pkg.sv
// Shared definitions for the sequencer print formatter: ASCII constants and FSM encodings.
package seq_definitions;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StWait = 3'd2,
    StStb  = 3'd3,
    StGap  = 3'd4
  } seq_state_e;

  // What the current line index points at.
  typedef enum logic [1:0] {
    KindDigit = 2'd0,
    KindSpace = 2'd1,
    KindCr    = 2'd2,
    KindLf    = 2'd3
  } byte_kind_e;

endpackage

// File: rtl/seq_hex_fmt_if.sv
// Value-in / byte-out bus of the hex print formatter; master is the formatter side.
interface seq_hex_fmt_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_busy;
  logic [7:0]        o_tx_data;
  logic              o_tx_stb;
  logic              i_tx_busy;
  logic              o_ovf;

  modport master (
    input  i_data, i_valid, i_tx_busy,
    output o_busy, o_tx_data, o_tx_stb, o_ovf
  );

  modport slave (
    output i_data, i_valid, i_tx_busy,
    input  o_busy, o_tx_data, o_tx_stb, o_ovf
  );
endinterface

// File: rtl/seq_hex_ascii.sv
// Combinational nibble to uppercase ASCII hex character.
module seq_hex_ascii
  import seq_definitions::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nibble_i < 4'd10) begin
      ascii_o = CH_0 + {4'b0000, nibble_i};
    end else begin
      ascii_o = CH_A + {4'b0000, nibble_i} - 8'd10;
    end
  end

endmodule

// File: rtl/seq_hex_fmt.sv
// Captures a value, prints it as ASCII hex (MSB nibble first) with optional spaces and CR/LF,
// one byte per UART strobe/busy handshake.
module seq_hex_fmt
  import seq_definitions::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TERM_EN  = 1,
  parameter int unsigned SPACE_EN = 0
) (
  input logic           clk,
  input logic           rst,
  seq_hex_fmt_if.master bus
);

  localparam int unsigned NDIG    = (DATA_W + 3) / 4;
  localparam int unsigned CapW    = 4 * NDIG;
  // One space between value bytes; an odd leading digit forms its own byte.
  localparam int unsigned NSP     = (SPACE_EN != 0) ? (NDIG + 1) / 2 - 1 : 0;
  localparam int unsigned NTERM   = (TERM_EN != 0) ? 2 : 0;
  localparam int unsigned LineLen = NDIG + NSP + NTERM;
  localparam int unsigned IdxW    = $clog2(LineLen + 1);

  seq_state_e        state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CapW-1:0]   cap_q, cap_d;
  logic              busy_q, busy_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_stb_q, tx_stb_d;
  logic              ovf_q, ovf_d;

  logic [3:0]        nib;
  logic [7:0]        nib_ascii;
  logic [7:0]        sel_byte;
  byte_kind_e        kind;

  seq_hex_ascii u_ascii (
    .nibble_i (nib),
    .ascii_o  (nib_ascii)
  );

  // Walk the line layout (digits, interleaved spaces, CR, LF) to classify idx_q.
  always_comb begin
    int pos;
    nib  = '0;
    kind = KindLf;
    pos  = 0;
    for (int d = int'(NDIG) - 1; d >= 0; d--) begin
      if (int'(idx_q) == pos) begin
        nib  = cap_q[4*d +: 4];
        kind = KindDigit;
      end
      pos = pos + 1;
      if (SPACE_EN != 0 && d != 0 && (d % 2) == 0) begin
        if (int'(idx_q) == pos) begin
          kind = KindSpace;
        end
        pos = pos + 1;
      end
    end
    if (int'(idx_q) == pos) begin
      kind = KindCr;
    end
  end

  always_comb begin
    sel_byte = CH_LF;
    unique case (kind)
      KindDigit: sel_byte = nib_ascii;
      KindSpace: sel_byte = CH_SP;
      KindCr:    sel_byte = CH_CR;
      KindLf:    sel_byte = CH_LF;
      default:   sel_byte = CH_LF;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cap_d     = cap_q;
    busy_d    = busy_q;
    tx_data_d = tx_data_q;
    tx_stb_d  = 1'b0;
    ovf_d     = ovf_q;

    if (bus.i_valid && busy_q) begin
      ovf_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.i_valid) begin
          cap_d   = CapW'(bus.i_data);
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        tx_data_d = sel_byte;
        state_d   = StWait;
      end
      StWait: begin
        if (!bus.i_tx_busy) begin
          tx_stb_d = 1'b1;
          state_d  = StStb;
        end
      end
      StStb: begin
        state_d = StGap;
      end
      // Gives the UART its one-cycle busy latency before busy is looked at again.
      StGap: begin
        if (int'(idx_q) == int'(LineLen) - 1) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cap_q     <= '0;
      busy_q    <= 1'b0;
      tx_data_q <= '0;
      tx_stb_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cap_q     <= cap_d;
      busy_q    <= busy_d;
      tx_data_q <= tx_data_d;
      tx_stb_q  <= tx_stb_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.o_busy    = busy_q;
  assign bus.o_tx_data = tx_data_q;
  assign bus.o_tx_stb  = tx_stb_q;
  assign bus.o_ovf     = ovf_q;

endmodule

// File: tb/tb_seq_hex_fmt.sv
// Directed bench for seq_hex_fmt: three configurations, each with its own UART busy model.
module tb_seq_hex_fmt;

  localparam int Hold0 = 10;
  localparam int Hold1 = 3;
  localparam int Hold2 = 0;

  logic        clk = 1'b0;
  logic        rst0, rst1, rst2;
  logic        vld [3];
  logic [31:0] din [3];
  logic        force0;
  int          cnt0 = 0, cnt1 = 0, cnt2 = 0;
  int          cyc = 0;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  seq_hex_fmt_if #(.DATA_W(8))  if0 ();
  seq_hex_fmt_if #(.DATA_W(16)) if1 ();
  seq_hex_fmt_if #(.DATA_W(5))  if2 ();

  assign if0.i_valid   = vld[0];
  assign if0.i_data    = din[0][7:0];
  assign if0.i_tx_busy = force0 | (cnt0 != 0);
  assign if1.i_valid   = vld[1];
  assign if1.i_data    = din[1][15:0];
  assign if1.i_tx_busy = (cnt1 != 0);
  assign if2.i_valid   = vld[2];
  assign if2.i_data    = din[2][4:0];
  assign if2.i_tx_busy = (cnt2 != 0);

  seq_hex_fmt #(.DATA_W(8), .TERM_EN(1), .SPACE_EN(0)) u_dut8 (
    .clk (clk), .rst (rst0), .bus (if0)
  );
  seq_hex_fmt #(.DATA_W(16), .TERM_EN(1), .SPACE_EN(1)) u_dut16 (
    .clk (clk), .rst (rst1), .bus (if1)
  );
  seq_hex_fmt #(.DATA_W(5), .TERM_EN(0), .SPACE_EN(0)) u_dut5 (
    .clk (clk), .rst (rst2), .bus (if2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy from the cycle after a strobe for HoldN cycles.
  always @(posedge clk) begin
    if (if0.o_tx_stb) cnt0 <= Hold0;
    else if (cnt0 > 0) cnt0 <= cnt0 - 1;
    if (if1.o_tx_stb) cnt1 <= Hold1;
    else if (cnt1 > 0) cnt1 <= cnt1 - 1;
    if (if2.o_tx_stb) cnt2 <= Hold2;
    else if (cnt2 > 0) cnt2 <= cnt2 - 1;
  end

  typedef struct {
    int         k;
    logic [7:0] b;
    int         c;
  } ev_t;
  ev_t evq[$];

  always @(negedge clk) begin
    if (if0.o_tx_stb) evq.push_back('{0, if0.o_tx_data, cyc});
    if (if1.o_tx_stb) evq.push_back('{1, if1.o_tx_data, cyc});
    if (if2.o_tx_stb) evq.push_back('{2, if2.o_tx_data, cyc});
  end

  typedef struct {
    int          k;
    logic [31:0] d;
    int          n;
    logic [55:0] exp;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  // {busy, stb, data[7:0], ovf}
  function automatic logic [10:0] outs_of(input int k);
    case (k)
      0:       return {if0.o_busy, if0.o_tx_stb, if0.o_tx_data, if0.o_ovf};
      1:       return {if1.o_busy, if1.o_tx_stb, if1.o_tx_data, if1.o_ovf};
      default: return {if2.o_busy, if2.o_tx_stb, if2.o_tx_data, if2.o_ovf};
    endcase
  endfunction

  function automatic int gap_of(input int k);
    int h;
    h = (k == 0) ? Hold0 : (k == 1) ? Hold1 : Hold2;
    return (h + 2 > 4) ? h + 2 : 4;
  endfunction

  function automatic int count_of(input int k);
    int n = 0;
    foreach (evq[i]) if (evq[i].k == k) n++;
    return n;
  endfunction

  task automatic collect(input int k, output logic [7:0] bs [8], output int cs [8],
                         output int n);
    n = 0;
    for (int j = 0; j < 8; j++) begin
      bs[j] = '0;
      cs[j] = 0;
    end
    foreach (evq[i]) begin
      if (evq[i].k == k && n < 8) begin
        bs[n] = evq[i].b;
        cs[n] = evq[i].c;
        n++;
      end
    end
  endtask

  // Caller is at a negedge; valid is high for exactly the current cycle.
  task automatic pulse(input int k, input logic [31:0] d, output int vc);
    vld[k] = 1'b1;
    din[k] = d;
    vc = cyc;
    @(negedge clk);
    vld[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, output int fall);
    fall = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!outs_of(k)[10]) begin
        fall = cyc;
        return;
      end
    end
    fail_now($sformatf("inst%0d busy release", k));
  endtask

  task automatic check_bytes(input string tag, input int k, input int n, input logic [55:0] exp,
                             output logic [7:0] bs [8], output int cs [8], output int got_n);
    collect(k, bs, cs, got_n);
    check({tag, " count"}, got_n, n);
    for (int j = 0; j < n && j < got_n; j++) begin
      check($sformatf("%s byte%0d", tag, j), int'(bs[j]), int'(exp[55-8*j -: 8]));
    end
  endtask

  task automatic run_line(input int k, input logic [31:0] d, input int n, input logic [55:0] exp,
                          input string tag, input int ovf_at);
    logic [7:0] bs [8];
    int cs [8];
    int got_n, vc, vc2, fall;
    evq.delete();
    @(negedge clk);
    pulse(k, d, vc);
    if (ovf_at > 0) begin
      repeat (ovf_at - 1) @(negedge clk);
      pulse(k, 32'h77, vc2);
    end
    wait_done(k, 600, fall);
    check_bytes(tag, k, n, exp, bs, cs, got_n);
    if (got_n > 0) begin
      check({tag, " latency"}, cs[0] - vc, 3);
      check({tag, " busy fall"}, fall - cs[got_n-1], 2);
    end
    for (int j = 1; j < got_n; j++) begin
      check($sformatf("%s spacing%0d", tag, j), cs[j] - cs[j-1], gap_of(k));
    end
    check({tag, " ovf"}, int'(outs_of(k)[0]), (ovf_at > 0) ? 1 : 0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] bs [8];
    int cs [8];
    int got_n, vc, vc2, fall, x, waited;

    vecs[0] = '{0, 32'h3C,   4, 56'h33430D0A000000};
    vecs[1] = '{0, 32'h00,   4, 56'h30300D0A000000};
    vecs[2] = '{0, 32'hF9,   4, 56'h46390D0A000000};
    vecs[3] = '{1, 32'hA05F, 7, 56'h41302035460D0A};
    vecs[4] = '{1, 32'h1234, 7, 56'h31322033340D0A};
    vecs[5] = '{2, 32'h1F,   2, 56'h31460000000000};
    vecs[6] = '{2, 32'h0A,   2, 56'h30410000000000};

    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0;
      din[k] = '0;
    end
    force0 = 1'b0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    rst2 = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset inst%0d busy", k), int'(outs_of(k)[10]), 0);
      check($sformatf("reset inst%0d stb", k),  int'(outs_of(k)[9]),  0);
      check($sformatf("reset inst%0d data", k), int'(outs_of(k)[8:1]), 0);
      check($sformatf("reset inst%0d ovf", k),  int'(outs_of(k)[0]),  0);
    end
    rst0 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_line(vecs[i].k, vecs[i].d, vecs[i].n, vecs[i].exp, $sformatf("vec%0d", i), 0);
    end

    // Second valid while busy is dropped and flags overflow until reset.
    run_line(0, 32'h3C, 4, 56'h33430D0A000000, "ovf line", 5);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    check("ovf after reset", int'(outs_of(0)[0]), 0);

    // Valid in the very cycle busy drops is accepted.
    evq.delete();
    @(negedge clk);
    pulse(2, 32'h1F, vc);
    wait_done(2, 200, fall);
    pulse(2, 32'h0A, vc2);
    wait_done(2, 200, fall);
    collect(2, bs, cs, got_n);
    check("idle entry count", got_n, 4);
    check("idle entry byte2", int'(bs[2]), 8'h30);
    check("idle entry byte3", int'(bs[3]), 8'h41);
    check("idle entry latency", cs[2] - vc2, 3);
    check("idle entry ovf", int'(outs_of(2)[0]), 0);
    repeat (10) @(negedge clk);

    // UART still busy from an earlier user when the value arrives.
    evq.delete();
    force0 = 1'b1;
    @(negedge clk);
    pulse(0, 32'h3C, vc);
    repeat (49) @(negedge clk);
    check("held busy no strobe", count_of(0), 0);
    force0 = 1'b0;
    x = cyc;
    wait_done(0, 600, fall);
    check_bytes("held busy", 0, 4, 56'h33430D0A000000, bs, cs, got_n);
    check("held busy first strobe", cs[0] - x, 1);
    repeat (20) @(negedge clk);

    // Reset after the second strobe aborts the line.
    evq.delete();
    @(negedge clk);
    pulse(0, 32'h3C, vc);
    waited = 0;
    while (count_of(0) < 2 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) fail_now("abort second strobe");
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    check("abort outputs", int'(outs_of(0)), 0);
    repeat (40) @(negedge clk);
    check("abort no more strobes", count_of(0), 2);
    run_line(0, 32'h00, 4, 56'h30300D0A000000, "after abort", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
